// File: rtl/tree_sim_pkg.sv
// Shared definitions for the tree-traversal scheduler blocks.
//
// Holds the result-word layout (RES_W wide, leaf ID in the upper ID_W bits
// starting at LEAF_ID_LSB), the tree node width, and the collector state enum.
//
// No ports: this is a package.
package tree_sim_pkg;

  localparam int RES_W       = 42;
  localparam int LEAF_ID_LSB = 32;
  localparam int ID_W        = 10;
  localparam int NODE_W      = 222;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } leaf_arb_state_t;

endpackage

// File: rtl/leaf_result_arbiter_if.sv
// Leaf-result source bus: per-source valid/ready handshake plus a packed
// vector of result words (source i occupies [i*RES_W +: RES_W]).
//
// Ports (signals):
//   src_valid  NUM_SRC        source has a result word to offer
//   src_data   NUM_SRC*RES_W  result words, held stable until granted
//   src_ready  NUM_SRC        one-hot grant from the arbiter
// Modports:
//   master  the leaf-producing PEs (drive valid/data, see ready)
//   slave   the arbiter (sees valid/data, drives ready)
interface leaf_result_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int RES_W   = 42
);

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*RES_W-1:0] src_data;
  logic [NUM_SRC-1:0]       src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);

endinterface

// File: rtl/leaf_result_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter (module rr_arbiter).
//
// The request vector is rotated so that position ptr lands at index 0, the
// lowest set bit is picked, and the pick is rotated back. The requester at
// ptr therefore has the highest priority, then ptr+1, ... wrapping N-1 -> 0.
//
// Ports:
//   req  in  N      request vector
//   ptr  in  PTR_W  highest-priority requester (must be < N)
//   gnt  out N      one-hot grant, zero when no request is set
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0]     req_rot;
  logic [N-1:0]     pick_rot;
  logic [PTR_W-1:0] pos;
  logic             found;

  always_comb begin
    req_rot  = '0;
    pick_rot = '0;
    gnt      = '0;
    pos      = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos        = PTR_W'((int'(ptr) + k) % N);
      req_rot[k] = req[pos];
    end
    for (int k = 0; k < N; k++) begin
      if (req_rot[k] && !found) begin
        pick_rot[k] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      pos      = PTR_W'((int'(ptr) + k) % N);
      gnt[pos] = pick_rot[k];
    end
  end

endmodule

// File: rtl/leaf_result_arbiter.sv
// Leaf result collector for the tree-traversal scheduler.
//
// Round-robin arbitrates finished leaf words from the leaf-producing PEs,
// writes each into a leaf-indexed store, tracks occupancy and a unique-leaf
// count, flags duplicate / out-of-range IDs, and reports when the expected
// number of leaves for one run has been collected.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             pulse: arm collection, samples expected_leaves
//   clear             pulse: wipe occupancy, count and errors (wins over start)
//   expected_leaves   leaves expected in the current tree
//   src               leaf_result_arbiter_if.slave source bus
//   rd_addr/rd_data   host read port, 1-cycle registered latency
//   leaf_count        accepted unique leaves (saturates at DEPTH)
//   busy / done       collecting / run complete
//   err_dup/err_range sticky error flags
// Optional (macro LEAF_ARB_STATS_EN):
//   src_accept_cnt    per-source 8-bit saturating accepted-transfer counters
//   stall_cycles      16-bit saturating count of COLLECT cycles with a
//                     valid-but-not-ready source
module leaf_result_arbiter
  import tree_sim_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [ADDR_W:0]      expected_leaves,
  leaf_result_arbiter_if.slave src,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [RES_W-1:0]     rd_data,
  output logic [ADDR_W:0]      leaf_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_dup,
  output logic                 err_range
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [NUM_SRC*8-1:0] src_accept_cnt,
  output logic [15:0]          stall_cycles
`endif
);

  localparam int              PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ID_W-1:0] ID_LIMIT  = ID_W'(DEPTH);

  leaf_arb_state_t    state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [ADDR_W:0]    exp_q;
  logic [DEPTH-1:0]   occ;
  logic [RES_W-1:0]   store [DEPTH];

  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] sel;
  logic               xfer;
  logic [PTR_W-1:0]   sel_idx;
  logic [RES_W-1:0]   word;
  logic [ID_W-1:0]    id;

  rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
    .req (src.src_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Grants are only offered while collecting and still short of the target.
  // Once leaf_count hits the target the FSM spends one more cycle in COLLECT
  // before DONE; holding ready low there keeps surplus words with their
  // sources instead of silently swallowing them.
  always_comb begin
    ready   = '0;
    sel_idx = '0;
    word    = '0;
    if (state == COLLECT && !clear && leaf_count != exp_q) begin
      ready = gnt;
    end
    sel  = src.src_valid & ready;
    xfer = |sel;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i]) begin
        sel_idx = PTR_W'(i);
        word    = src.src_data[i*RES_W +: RES_W];
      end
    end
    id = word[RES_W-1:LEAF_ID_LSB];
  end

  assign src.src_ready = ready;
  assign busy          = (state == COLLECT);
  assign done          = (state == DONE);

  // Main FSM, store, occupancy bitmap and flags. clear outranks everything
  // but reset; the store survives clear and simply goes stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      exp_q      <= '0;
      occ        <= '0;
      leaf_count <= '0;
      err_dup    <= 1'b0;
      err_range  <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      rd_data <= store[rd_addr];
      if (clear) begin
        state      <= IDLE;
        occ        <= '0;
        leaf_count <= '0;
        err_dup    <= 1'b0;
        err_range  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              exp_q <= expected_leaves;
              state <= (expected_leaves == '0) ? DONE : COLLECT;
            end
          end
          COLLECT: begin
            if (leaf_count == exp_q) begin
              state <= DONE;
            end
            if (xfer) begin
              rr_ptr <= (sel_idx == PTR_W'(NUM_SRC-1)) ? '0 : sel_idx + PTR_W'(1);
              // An all-zero word means "no result": consumed, nothing recorded.
              if (word != '0) begin
                if (id >= ID_LIMIT) begin
                  err_range <= 1'b1;
                end else if (occ[id[ADDR_W-1:0]]) begin
                  err_dup <= 1'b1;
                end else begin
                  store[id[ADDR_W-1:0]] <= word;
                  occ[id[ADDR_W-1:0]]   <= 1'b1;
                  if (leaf_count != COUNT_MAX) begin
                    leaf_count <= leaf_count + COUNT_ONE;
                  end
                end
              end
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LEAF_ARB_STATS_EN
  logic [7:0] acc_cnt [NUM_SRC];

  // Every accepted transfer counts, including discarded zero/dup/range words.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stall_cycles <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        acc_cnt[i] <= '0;
      end
    end else begin
      if (xfer && acc_cnt[sel_idx] != 8'hFF) begin
        acc_cnt[sel_idx] <= acc_cnt[sel_idx] + 8'd1;
      end
      if (state == COLLECT && |(src.src_valid & ~ready) && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_acc
    assign src_accept_cnt[g*8 +: 8] = acc_cnt[g];
  end
`endif

endmodule
